hms_time_ctrl: RTL and testbench

//  Time-of-day counter (HH:MM:SS) with a button-driven time-set FSM; upstream stage of the six-digit FND display path.

---
 rtl/hms_time_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_hms_time_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hms_time_ctrl.sv
// ---------------------------------------------------------------------------
// hms_time_ctrl
//
// Time-of-day counter (HH:MM:SS) with a button-driven time-set FSM. It is the
// upstream stage of the six-digit FND display path. Time advances on a 1 Hz
// single-cycle tick. In SET mode the buttons edit one field at a time, and the
// decimal points of that field blink.
//
// Parameters
//   HOUR_MAX   last hour value before wrapping to 0 (11 or 23)
//
// Ports
//   clk          system clock, all logic on posedge
//   rst          synchronous, active-high reset
//   i_tick       1-cycle pulse, once per second
//   i_sw_mode    1-cycle pulse: toggle RUN/SET
//   i_sw_sel     1-cycle pulse: in SET, advance selected field SEC->MIN->HOUR
//   i_sw_inc     1-cycle pulse: in SET, increment selected field (no carry)
//   o_sec        seconds, binary 0..59
//   o_min        minutes, binary 0..59
//   o_hour       hours, binary 0..HOUR_MAX
//   o_six_bcd    {h10,h1,m10,m1,s10,s1}; lags the counters by one cycle
//   o_six_dp     decimal point per digit, 1 = lit, bit 0 = rightmost digit
//   o_mode       0 = RUN, 1 = SET
// ---------------------------------------------------------------------------
module hms_time_ctrl #(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_sw_mode,
  input  logic        i_sw_sel,
  input  logic        i_sw_inc,
  output logic [5:0]  o_sec,
  output logic [5:0]  o_min,
  output logic [4:0]  o_hour,
  output logic [23:0] o_six_bcd,
  output logic [5:0]  o_six_dp,
  output logic        o_mode
);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    F_SEC  = 2'd0,
    F_MIN  = 2'd1,
    F_HOUR = 2'd2
  } field_e;

  localparam logic [4:0] HourMax = 5'(HOUR_MAX);
  localparam logic [5:0] DpRun   = 6'b010100;

  state_e      state_q, state_d;
  field_e      field_q, field_d;
  logic        blink_q, blink_d;
  logic [5:0]  sec_q,   sec_d;
  logic [5:0]  min_q,   min_d;
  logic [4:0]  hour_q,  hour_d;
  logic [5:0]  dp_q,    dp_d;
  logic [23:0] bcd_q;

  // ">=" rather than "==" so a value forced out of range wraps to 0 on the
  // next increment instead of counting on upward.
  function automatic logic [5:0] inc_60(input logic [5:0] v);
    return (v >= 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hour(input logic [4:0] v);
    return (v >= HourMax) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] tens;
    logic [5:0] ones;
    tens = v / 6'd10;
    ones = v - tens * 6'd10;
    return {tens[3:0], ones[3:0]};
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    state_d = state_q;
    field_d = field_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    blink_d = blink_q ^ i_tick;

    unique case (state_q)
      ST_RUN: begin
        // The tick is applied even when mode is pressed in the same cycle.
        // sel/inc are ignored while running.
        if (i_tick) begin
          sec_d = inc_60(sec_q);
          if (sec_q >= 6'd59) begin
            min_d = inc_60(min_q);
            if (min_q >= 6'd59) begin
              hour_d = inc_hour(hour_q);
            end
          end
        end
        if (i_sw_mode) begin
          state_d = ST_SET;
          field_d = F_SEC;
          blink_d = 1'b0;
        end
      end

      ST_SET: begin
        // Time is frozen here. Button priority is mode > sel > inc.
        if (i_sw_mode) begin
          state_d = ST_RUN;
        end else if (i_sw_sel) begin
          case (field_q)
            F_SEC:   field_d = F_MIN;
            F_MIN:   field_d = F_HOUR;
            default: field_d = F_SEC;
          endcase
        end else if (i_sw_inc) begin
          case (field_q)
            F_SEC:   sec_d  = inc_60(sec_q);
            F_MIN:   min_d  = inc_60(min_q);
            default: hour_d = inc_hour(hour_q);
          endcase
        end
      end

      default: state_d = ST_RUN;
    endcase

    // The decimal points are derived from next-state values so that they
    // update in the same cycle as the state and counters.
    dp_d = DpRun;
    if (state_d == ST_SET) begin
      case (field_d)
        F_SEC:   dp_d = {4'b0000, {2{blink_d}}};
        F_MIN:   dp_d = {2'b00, {2{blink_d}}, 2'b00};
        default: dp_d = {{2{blink_d}}, 4'b0000};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge.
    if (rst) begin
      state_q <= ST_RUN;
      field_q <= F_SEC;
      blink_q <= 1'b0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      dp_q    <= DpRun;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      blink_q <= blink_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      dp_q    <= dp_d;
      // BCD is converted from the registered counters, so it is one cycle
      // behind them.
      bcd_q   <= {to_bcd({1'b0, hour_q}), to_bcd(min_q), to_bcd(sec_q)};
    end
  end

  assign o_sec     = sec_q;
  assign o_min     = min_q;
  assign o_hour    = hour_q;
  assign o_six_bcd = bcd_q;
  assign o_six_dp  = dp_q;
  assign o_mode    = (state_q == ST_SET);

endmodule

// File: tb/tb_hms_time_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hms_time_ctrl
//
// Directed bench for hms_time_ctrl. A behavioural model holds time as
// seconds-of-day plus mode, field and blink. A negedge process compares every
// DUT output with the model on each cycle. Hand-computed literal checks in the
// stimulus pin the model to the expected behaviour.
// ---------------------------------------------------------------------------
module tb_hms_time_ctrl;

  localparam int HM  = 23;
  localparam int DAY = (HM + 1) * 3600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_tick = 1'b0;
  logic        i_sw_mode = 1'b0;
  logic        i_sw_sel = 1'b0;
  logic        i_sw_inc = 1'b0;
  logic [5:0]  o_sec;
  logic [5:0]  o_min;
  logic [4:0]  o_hour;
  logic [23:0] o_six_bcd;
  logic [5:0]  o_six_dp;
  logic        o_mode;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Model state.
  int          m_t = 0;
  int          m_field = 0;
  bit          m_set = 1'b0;
  bit          m_blink = 1'b0;
  logic [23:0] m_bcd = '0;

  always #5 clk = ~clk;

  hms_time_ctrl #(.HOUR_MAX(HM)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_tick    (i_tick),
    .i_sw_mode (i_sw_mode),
    .i_sw_sel  (i_sw_sel),
    .i_sw_inc  (i_sw_inc),
    .o_sec     (o_sec),
    .o_min     (o_min),
    .o_hour    (o_hour),
    .o_six_bcd (o_six_bcd),
    .o_six_dp  (o_six_dp),
    .o_mode    (o_mode)
  );

  function automatic logic [23:0] bcd_of(input int t);
    int h;
    int m;
    int s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [5:0] dp_of(input bit set, input int field, input bit blink);
    if (!set) return 6'b010100;
    if (!blink) return 6'b000000;
    return 6'(3 << (2 * field));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Behavioural model, advanced at each clock edge.
  always @(posedge clk) begin : model
    int h;
    int m;
    int s;
    if (rst) begin
      m_t = 0; m_set = 1'b0; m_field = 0; m_blink = 1'b0; m_bcd = '0;
    end else begin
      m_bcd = bcd_of(m_t);
      if (i_tick) m_blink = !m_blink;
      if (!m_set) begin
        if (i_tick) m_t = (m_t + 1) % DAY;
        if (i_sw_mode) begin
          m_set = 1'b1; m_field = 0; m_blink = 1'b0;
        end
      end else if (i_sw_mode) begin
        m_set = 1'b0;
      end else if (i_sw_sel) begin
        m_field = (m_field + 1) % 3;
      end else if (i_sw_inc) begin
        h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        case (m_field)
          0:       s = (s + 1) % 60;
          1:       m = (m + 1) % 60;
          default: h = (h + 1) % (HM + 1);
        endcase
        m_t = h * 3600 + m * 60 + s;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc sec",  32'(o_sec),     32'(m_t % 60));
      check("cyc min",  32'(o_min),     32'((m_t / 60) % 60));
      check("cyc hour", 32'(o_hour),    32'(m_t / 3600));
      check("cyc mode", 32'(o_mode),    32'(m_set));
      check("cyc dp",   32'(o_six_dp),  32'(dp_of(m_set, m_field, m_blink)));
      check("cyc bcd",  32'(o_six_bcd), 32'(m_bcd));
    end
  end

  task automatic step(input bit t, input bit md, input bit sl, input bit inc);
    i_tick = t; i_sw_mode = md; i_sw_sel = sl; i_sw_inc = inc;
    @(posedge clk);
    @(negedge clk);
    i_tick = 1'b0; i_sw_mode = 1'b0; i_sw_sel = 1'b0; i_sw_inc = 1'b0;
  endtask

  task automatic incs(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    check({name, " hour"}, 32'(o_hour), 32'(h));
    check({name, " min"},  32'(o_min),  32'(m));
    check({name, " sec"},  32'(o_sec),  32'(s));
  endtask

  initial begin
    // 1. reset
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    check_time("reset", 0, 0, 0);
    check("reset mode", 32'(o_mode),    32'd0);
    check("reset dp",   32'(o_six_dp),  32'h14);
    check("reset bcd",  32'(o_six_bcd), 32'h000000);

    // 2. preload 23:59:58 and roll over midnight
    step(0, 1, 0, 0);
    incs(58);
    step(0, 0, 1, 0);
    incs(59);
    step(0, 0, 1, 0);
    incs(23);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("preload bcd", 32'(o_six_bcd), 32'h235958);
    check("preload mode", 32'(o_mode), 32'd0);
    step(1, 0, 0, 0);
    check_time("tick1", 23, 59, 59);
    step(1, 0, 0, 0);
    check_time("tick2", 0, 0, 0);
    step(0, 0, 0, 0);
    check("wrap bcd", 32'(o_six_bcd), 32'h000000);

    // 3. edit sequence
    step(0, 1, 0, 0);
    check("edit mode", 32'(o_mode), 32'd1);
    check("edit dp0", 32'(o_six_dp), 32'h00);
    incs(3);
    check("edit sec3", 32'(o_sec), 32'd3);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    check("field min dp", 32'(o_six_dp), 32'h0C);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("field hour dp", 32'(o_six_dp), 32'h30);
    incs(25);
    check_time("hour wrap", 1, 0, 3);
    step(0, 1, 0, 0);
    check("exit mode", 32'(o_mode), 32'd0);
    check("exit dp", 32'(o_six_dp), 32'h14);
    check_time("exit", 1, 0, 3);

    // 4. sec wrap without carry, ticks frozen in SET
    step(0, 1, 0, 0);
    incs(56);
    check("sec59", 32'(o_sec), 32'd59);
    step(0, 0, 0, 1);
    check_time("sec wrap", 1, 0, 0);
    step(1, 0, 0, 0);
    check("blink on", 32'(o_six_dp), 32'h03);
    step(1, 0, 0, 0);
    check("blink off", 32'(o_six_dp), 32'h00);
    step(1, 0, 0, 0);
    check("blink on2", 32'(o_six_dp), 32'h03);
    check_time("frozen", 1, 0, 0);
    step(0, 1, 0, 0);

    // 5. simultaneous pulses
    step(0, 1, 1, 1);
    check("simul mode", 32'(o_mode), 32'd1);
    check_time("simul", 1, 0, 0);
    step(1, 0, 0, 0);
    check("simul field sec", 32'(o_six_dp), 32'h03);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    incs(23);
    check("hour to 0", 32'(o_hour), 32'd0);
    step(0, 0, 1, 0);
    incs(9);
    check_time("at 9", 0, 0, 9);
    step(0, 1, 0, 0);
    check("run again", 32'(o_mode), 32'd0);
    step(1, 1, 0, 0);
    check("tick+mode sec", 32'(o_sec), 32'd10);
    check("tick+mode mode", 32'(o_mode), 32'd1);

    // 6. reset in SET with field HOUR
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    incs(5);
    check("pre-rst hour", 32'(o_hour), 32'd5);
    rst = 1'b1;
    step(0, 0, 0, 1);
    rst = 1'b0;
    check_time("mid rst", 0, 0, 0);
    check("mid rst mode", 32'(o_mode), 32'd0);
    check("mid rst dp", 32'(o_six_dp), 32'h14);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
